iserdes_word_aligner_10b: RTL and testbench

//  Receive-side counterpart of the 10:1 DDR serializer in the timing generator link.

---
 rtl/cmlk_rx_pkg.sv | 22 ++
 rtl/cmlk_word_window.sv | 15 +
 rtl/iserdes_word_aligner_10b.sv | 162 ++++++++++++++++
 tb/tb_iserdes_word_aligner_10b.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmlk_rx_pkg.sv
// Shared types and constants for the Camera Link receive word aligner.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: word/offset widths, alignment FSM state enum, offset wrap helper.
package cmlk_rx_pkg;

  localparam int WORD_W = 10;
  localparam int OFS_W  = 4;
  localparam logic [OFS_W-1:0] OFS_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    VERIFY,
    LOCKED
  } state_e;

  // Next bit offset to try; wraps 9 -> 0 so the offset never leaves 0..9.
  function automatic logic [OFS_W-1:0] ofs_next(input logic [OFS_W-1:0] ofs);
    return (ofs == OFS_MAX) ? '0 : ofs + 4'd1;
  endfunction

endpackage

// File: rtl/cmlk_word_window.sv
// Offset selector: picks a 10-bit candidate word out of a 20-bit two-word window.
// Latency: combinational. Backpressure: none.
// Ports: win (in 20, {newest word, previous word}), slip_ofs (in 4, 0..9), cand (out 10).
module cmlk_word_window
  import cmlk_rx_pkg::*;
(
  input  logic [2*WORD_W-1:0] win,
  input  logic [OFS_W-1:0]    slip_ofs,
  output logic [WORD_W-1:0]   cand
);

  // cand = win[slip_ofs+9 : slip_ofs]; bit0 of win is the earliest received bit.
  assign cand = WORD_W'(win >> slip_ofs);

endmodule

// File: rtl/iserdes_word_aligner_10b.sv
// Word aligner behind a 1:10 deserializer: slides a bit offset until TRAIN_PATTERN matches,
// verifies LOCK_COUNT consecutive matches, then emits aligned words. Latency: 1 cycle from raw_valid.
// Backpressure: none; words are accepted whenever raw_valid=1, nothing happens on raw_valid=0.
// Ports: clk, rst_n (async active-low), align_en, train_en, raw_data[9:0], raw_valid,
//        dout[9:0], dout_valid, locked, slip_ofs[3:0]; err_cnt[15:0] only with WORD_ALIGN_ERRCNT_EN.
// Optional macro WORD_ALIGN_ERRCNT_EN: adds a saturating count of mismatches seen while locked
// with training on, cleared on entry to LOCKED.
module iserdes_word_aligner_10b
  import cmlk_rx_pkg::*;
#(
  parameter logic [9:0] TRAIN_PATTERN = 10'h3E0,
  parameter int         LOCK_COUNT    = 16,
  parameter int         UNLOCK_COUNT  = 4
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        align_en,
  input  logic        train_en,
  input  logic [9:0]  raw_data,
  input  logic        raw_valid,
  output logic [9:0]  dout,
  output logic        dout_valid,
  output logic        locked,
  output logic [3:0]  slip_ofs
`ifdef WORD_ALIGN_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [15:0] LOCK_N   = 16'(LOCK_COUNT);
  localparam logic [15:0] UNLOCK_N = 16'(UNLOCK_COUNT);

  state_e              state_q;
  logic [WORD_W-1:0]   prev_q;
  logic [OFS_W-1:0]    ofs_q;
  logic [15:0]         match_cnt_q;
  logic [15:0]         miss_cnt_q;
  logic [WORD_W-1:0]   dout_q;
  logic                dout_valid_q;
  logic                locked_q;
`ifdef WORD_ALIGN_ERRCNT_EN
  logic [15:0]         err_cnt_q;
`endif

  logic [WORD_W-1:0]   cand;
  logic                match;
  logic [OFS_W-1:0]    ofs_d;
  logic [15:0]         match_cnt_d;
  logic [15:0]         miss_cnt_d;
  logic                lock_hit;
  logic                drop_hit;

  cmlk_word_window u_window (
    .win      ({raw_data, prev_q}),
    .slip_ofs (ofs_q),
    .cand     (cand)
  );

  assign match       = (cand == TRAIN_PATTERN);
  assign ofs_d       = ofs_next(ofs_q);
  assign match_cnt_d = match_cnt_q + 16'd1;
  assign miss_cnt_d  = miss_cnt_q + 16'd1;

  // match_cnt_q is always 0 in SEARCH, so one compare covers both the
  // LOCK_COUNT=1 shortcut from SEARCH and the normal end of VERIFY.
  assign lock_hit = match && ((state_q == SEARCH) || (state_q == VERIFY)) &&
                    (match_cnt_d == LOCK_N);
  assign drop_hit = (state_q == LOCKED) && train_en && !match && (miss_cnt_d == UNLOCK_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      ofs_q        <= '0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
`ifdef WORD_ALIGN_ERRCNT_EN
      err_cnt_q    <= '0;
`endif
    end else if (!align_en) begin
      // Offset is kept so a later re-enable resumes from the last known boundary.
      state_q      <= IDLE;
      prev_q       <= '0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
    end else if (state_q == IDLE) begin
      // prev_q stays 0 here so the first searched word sees an all-zero history.
      state_q      <= SEARCH;
      dout_valid_q <= 1'b0;
    end else begin
      // The word that drops lock is not forwarded.
      dout_valid_q <= raw_valid && (state_q == LOCKED) && !drop_hit;
      if (raw_valid) begin
        prev_q <= raw_data;
        dout_q <= cand;
        if (lock_hit) begin
          state_q     <= LOCKED;
          locked_q    <= 1'b1;
          match_cnt_q <= '0;
          miss_cnt_q  <= '0;
`ifdef WORD_ALIGN_ERRCNT_EN
          err_cnt_q   <= '0;
`endif
        end else begin
          case (state_q)
            SEARCH: begin
              if (match) begin
                state_q     <= VERIFY;
                match_cnt_q <= match_cnt_d;
              end else begin
                ofs_q <= ofs_d;
              end
            end
            VERIFY: begin
              if (match) begin
                match_cnt_q <= match_cnt_d;
              end else begin
                state_q     <= SEARCH;
                match_cnt_q <= '0;
                ofs_q       <= ofs_d;
              end
            end
            LOCKED: begin
              if (train_en && !match) begin
`ifdef WORD_ALIGN_ERRCNT_EN
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
`endif
                if (drop_hit) begin
                  // Offset is kept: the link most likely took a burst error, not a slip.
                  state_q    <= SEARCH;
                  locked_q   <= 1'b0;
                  miss_cnt_q <= '0;
                end else begin
                  miss_cnt_q <= miss_cnt_d;
                end
              end else begin
                miss_cnt_q <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = locked_q;
  assign slip_ofs   = ofs_q;
`ifdef WORD_ALIGN_ERRCNT_EN
  assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_iserdes_word_aligner_10b.sv
// Bench for iserdes_word_aligner_10b: hand tables and scenarios plus random traffic,
// all checked every cycle against a word-level reference model of the alignment rules.
// Optional macro WORD_ALIGN_ERRCNT_EN also checks err_cnt.
module tb_iserdes_word_aligner_10b;

  localparam int PAT = 'h3E0;
  localparam int LC  = 16;
  localparam int UC  = 4;

  localparam int M_IDLE   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_VERIFY = 2;
  localparam int M_LOCKED = 3;

  logic       clk;
  logic       rst_n;
  logic       align_en;
  logic       train_en;
  logic [9:0] raw_data;
  logic       raw_valid;
  logic [9:0] dout;
  logic       dout_valid;
  logic       locked;
  logic [3:0] slip_ofs;
`ifdef WORD_ALIGN_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int total;
  int bad;

  // Reference model state
  int   m_mode, m_ofs, m_run, m_miss, m_prev, m_dout, m_err;
  logic m_dv;

  typedef struct {
    logic       ae;
    logic       te;
    logic       rv;
    logic [9:0] rd;
    logic [3:0] e_ofs;
    logic       e_lock;
    logic       e_dv;
    logic [9:0] e_dout;
  } vec_t;

  vec_t tbl[6];

  iserdes_word_aligner_10b dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .align_en   (align_en),
    .train_en   (train_en),
    .raw_data   (raw_data),
    .raw_valid  (raw_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .slip_ofs   (slip_ofs)
`ifdef WORD_ALIGN_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Training word as seen by a deserializer whose boundary sits r bits off:
  // matches at slip offset r.
  function automatic int rot(input int r);
    if (r == 0) return PAT;
    return ((PAT << r) | (PAT >> (10 - r))) & 1023;
  endfunction

  function automatic int cand_of(input int raw, input int prev, input int ofs);
    return ((raw * 1024 + prev) >> ofs) & 1023;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_ofs = 0; m_run = 0; m_miss = 0;
    m_prev = 0; m_dout = 0; m_err = 0; m_dv = 1'b0;
  endtask

  task automatic model_update(input logic ae, input logic te, input logic rv, input logic [9:0] rd);
    int  c;
    bit  hit;
    if (!ae) begin
      m_mode = M_IDLE; m_prev = 0; m_run = 0; m_miss = 0; m_dout = 0; m_dv = 1'b0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_SEARCH; m_dv = 1'b0;
    end else begin
      m_dv = 1'b0;
      if (rv) begin
        c = cand_of(int'(rd), m_prev, m_ofs);
        hit = (c == PAT);
        m_dout = c;
        m_prev = int'(rd);
        if (m_mode == M_LOCKED) begin
          m_dv = 1'b1;
          if (te && !hit) begin
            m_miss++;
            if (m_err < 65535) m_err++;
            if (m_miss == UC) begin
              m_mode = M_SEARCH; m_miss = 0; m_dv = 1'b0;
            end
          end else begin
            m_miss = 0;
          end
        end else if (hit) begin
          m_run++;
          if (m_run == LC) begin
            m_mode = M_LOCKED; m_run = 0; m_miss = 0; m_err = 0;
          end else begin
            m_mode = M_VERIFY;
          end
        end else begin
          m_mode = M_SEARCH; m_run = 0; m_ofs = (m_ofs + 1) % 10;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("dout", 32'(dout), 32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_dv));
    chk("locked", 32'(locked), 32'(m_mode == M_LOCKED));
    chk("slip_ofs", 32'(slip_ofs), 32'(m_ofs));
`ifdef WORD_ALIGN_ERRCNT_EN
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
  endtask

  task automatic step(input logic ae, input logic te, input logic rv, input logic [9:0] rd);
    align_en = ae; train_en = te; raw_valid = rv; raw_data = rd;
    @(posedge clk);
    model_update(ae, te, rv, rd);
    #1;
    check_all();
  endtask

  task automatic stream(input int r, input int n, input logic te);
    for (int i = 0; i < n; i++) step(1'b1, te, 1'b1, 10'(rot(r)));
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk({nm, "_dout"}, 32'(dout), 32'h0);
    chk({nm, "_dv"}, 32'(dout_valid), 32'h0);
    chk({nm, "_locked"}, 32'(locked), 32'h0);
    chk({nm, "_ofs"}, 32'(slip_ofs), 32'h0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int         prevraw;
    int         r;
    logic       te_s;
    logic       ae;
    logic       rv;
    logic [9:0] rdv;

    total = 0; bad = 0;
    align_en = 1'b0; train_en = 1'b0; raw_valid = 1'b0; raw_data = '0;
    rst_n = 1'b0;
    model_reset();

    // Startup sequence, rotation 3 (raw word 0x307), hand-computed expectations.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 10'h000, 4'd0, 1'b0, 1'b0, 10'h000};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 10'h307, 4'd1, 1'b0, 1'b0, 10'h000};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 10'h307, 4'd1, 1'b0, 1'b0, 10'h000};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 10'h307, 4'd2, 1'b0, 1'b0, 10'h383};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 10'h307, 4'd3, 1'b0, 1'b0, 10'h3C1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 10'h307, 4'd3, 1'b0, 1'b0, 10'h3E0};

    #12;
    check_all();
    chk("reset_locked", 32'(locked), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      step(tbl[i].ae, tbl[i].te, tbl[i].rv, tbl[i].rd);
      chk("tbl_ofs", 32'(slip_ofs), 32'(tbl[i].e_ofs));
      chk("tbl_locked", 32'(locked), 32'(tbl[i].e_lock));
      chk("tbl_dv", 32'(dout_valid), 32'(tbl[i].e_dv));
      chk("tbl_dout", 32'(dout), 32'(tbl[i].e_dout));
    end

    // Scenario 1: one match done, lock after 15 more.
    stream(3, 14, 1'b1);
    chk("s1_not_yet", 32'(locked), 32'h0);
    stream(3, 1, 1'b1);
    chk("s1_lock", 32'(locked), 32'h1);
    chk("s1_lockword_hidden", 32'(dout_valid), 32'h0);
    chk("s1_ofs", 32'(slip_ofs), 32'h3);
    stream(3, 1, 1'b1);
    chk("s1_dout", 32'(dout), 32'h3E0);
    chk("s1_dv", 32'(dout_valid), 32'h1);

    // Scenario 3: bit0 flip only spoils the candidate of its own word at offset 3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 10'(rot(3) ^ 1));
    chk("s3_three_bad", 32'(locked), 32'h1);
    stream(3, 1, 1'b1);
    chk("s3_recovered", 32'(locked), 32'h1);
`ifdef WORD_ALIGN_ERRCNT_EN
    chk("s3_err3", 32'(err_cnt), 32'h3);
`endif
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 10'(rot(3) ^ 1));
    chk("s3_still", 32'(locked), 32'h1);
    step(1'b1, 1'b1, 1'b1, 10'(rot(3) ^ 1));
    chk("s3_drop", 32'(locked), 32'h0);
    chk("s3_drop_dv", 32'(dout_valid), 32'h0);
    chk("s3_drop_ofs", 32'(slip_ofs), 32'h3);
    stream(3, 16, 1'b1);
    chk("s3_relock", 32'(locked), 32'h1);
`ifdef WORD_ALIGN_ERRCNT_EN
    chk("s3_err0", 32'(err_cnt), 32'h0);
`endif

    // Scenario 4: payload with training off, realigned at offset 3.
    prevraw = rot(3);
    for (int i = 0; i < 40; i++) begin
      rdv = 10'($urandom_range(0, 1023));
      step(1'b1, 1'b0, 1'b1, rdv);
      chk("s4_dout", 32'(dout), 32'(cand_of(int'(rdv), prevraw, 3)));
      chk("s4_locked", 32'(locked), 32'h1);
      prevraw = int'(rdv);
    end

    // Scenario 6a: align_en dropped while locked.
    step(1'b0, 1'b1, 1'b1, 10'(rot(3)));
    chk("s6_dis_locked", 32'(locked), 32'h0);
    chk("s6_dis_dv", 32'(dout_valid), 32'h0);
    chk("s6_dis_dout", 32'(dout), 32'h0);
    chk("s6_dis_ofs", 32'(slip_ofs), 32'h3);

    // Scenario 2: rotation 9 walks the offset up, then rotation 0 forces the 9->0 wrap.
    do_reset("s2_rst");
    step(1'b1, 1'b1, 1'b0, 10'h0);
    for (int i = 0; i < 9; i++) begin
      stream(9, 1, 1'b1);
      chk("s2_walk", 32'(slip_ofs), 32'(i + 1));
    end
    stream(9, 16, 1'b1);
    chk("s2_lock9", 32'(locked), 32'h1);
    chk("s2_ofs9", 32'(slip_ofs), 32'h9);
    stream(0, 4, 1'b1);
    chk("s2_drop", 32'(locked), 32'h0);
    chk("s2_drop_ofs", 32'(slip_ofs), 32'h9);
    stream(0, 1, 1'b1);
    chk("s2_wrap", 32'(slip_ofs), 32'h0);
    stream(0, 16, 1'b1);
    chk("s2_lock0", 32'(locked), 32'h1);
    chk("s2_ofs0", 32'(slip_ofs), 32'h0);

    // Scenario 5: mismatch at VERIFY count 10, then raw_valid gaps.
    do_reset("s5_rst");
    step(1'b1, 1'b1, 1'b0, 10'h0);
    stream(2, 3, 1'b1);
    stream(2, 9, 1'b1);
    chk("s5_verify_ofs", 32'(slip_ofs), 32'h2);
    step(1'b1, 1'b1, 1'b1, 10'(rot(2) ^ 1));
    chk("s5_back_ofs", 32'(slip_ofs), 32'h3);
    chk("s5_back_locked", 32'(locked), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 10'($urandom_range(0, 1023)));
      chk("s5_gap_ofs", 32'(slip_ofs), 32'h3);
    end
    stream(2, 1, 1'b1);
    chk("s5_after_gap", 32'(slip_ofs), 32'h4);

    // Scenario 6b: reset mid-VERIFY (offset 2 reached again, a few matches in).
    stream(2, 12, 1'b1);
    do_reset("s6_rst");

    // Random traffic: long runs of one rotation, sparse bit errors, payload
    // stretches, valid gaps and rare align_en drops.
    r = 5;
    te_s = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) r = int'($urandom_range(0, 9));
      if ($urandom_range(0, 99) == 0) te_s = ~te_s;
      ae = ($urandom_range(0, 499) != 0);
      rv = ($urandom_range(0, 7) != 0);
      if (te_s)
        rdv = 10'(rot(r) ^ (($urandom_range(0, 49) == 0) ? (1 << $urandom_range(0, 9)) : 0));
      else
        rdv = 10'($urandom_range(0, 1023));
      step(ae, te_s, rv, rdv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
